// File: rtl/flash_pkg.sv
// Shared encodings for the parallel NOR flash controller: request ops,
// command bytes, status error mask and FSM state types.
package flash_pkg;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_PROG  = 2'b01;
    localparam logic [1:0] OP_ERASE = 2'b10;

    localparam logic [7:0] CMD_PROG    = 8'h40;
    localparam logic [7:0] CMD_ERASE   = 8'h20;
    localparam logic [7:0] CMD_CONFIRM = 8'hD0;
    localparam logic [7:0] CMD_RDSR    = 8'h70;
    localparam logic [7:0] CMD_CLRSR   = 8'h50;
    localparam logic [7:0] CMD_RDARR   = 8'hFF;

    // SR[5] erase fail, SR[4] program fail, SR[3] Vpp low, SR[1] block locked
    localparam logic [7:0] SR_ERR_MASK = 8'h3A;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_READ,
        ST_CMD1,
        ST_CMD2,
        ST_WAIT_STS,
        ST_STATUS,
        ST_CLR,
        ST_ARRAY,
        ST_FINISH
    } state_t;

    // Sub-phases of the write (SETUP..GAP) and read (RD, REC) bus cycles
    typedef enum logic [2:0] {
        PH_NONE,
        PH_SETUP,
        PH_WEL,
        PH_HOLD,
        PH_GAP,
        PH_RD,
        PH_REC
    } phase_t;

    function automatic logic sr_has_error(input logic [7:0] sr);
        return |(sr & SR_ERR_MASK);
    endfunction

endpackage

// File: rtl/flash_cycle_timer.sv
// Loadable down-counter that saturates at zero; times every bus-cycle
// phase as well as the NF_STS wait window.
module flash_cycle_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count,
    output logic             o_zero_c
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && !o_zero_c) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_zero_c = (r_count == '0);
    assign o_count  = r_count;

endmodule

// File: rtl/flash_ctrl.sv
// Parallel NOR flash controller: array read, word program and block erase
// with status polling, timeout and status-register error check.
module flash_ctrl
    import flash_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned T_RD      = 6,
    parameter int unsigned T_WP      = 4,
    parameter int unsigned T_WH      = 2,
    parameter int unsigned T_TIMEOUT = 50000000
) (
    input  logic              CLK_50MHZ,
    input  logic              RST,
    output logic              NF_CE,
    output logic              NF_BYTE,
    output logic              NF_OE,
    output logic              NF_RP,
    output logic              NF_WE,
    output logic              NF_WP,
    input  logic              NF_STS,
    output logic [ADDR_W-1:0] NF_A,
    inout  wire  [DATA_W-1:0] NF_D,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        op,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              error,
    output logic              timeout
);

    localparam int unsigned T_MAX_A = (T_RD > T_WP) ? T_RD : T_WP;
    localparam int unsigned T_MAX_B = (T_WH > T_TIMEOUT) ? T_WH : T_TIMEOUT;
    localparam int unsigned T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int unsigned CNT_W   = $clog2(T_MAX) + 1;

    state_t              r_state;
    phase_t              r_ph;
    logic                r_is_prog;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_d;
    logic                r_d_oe;
    logic [ADDR_W-1:0]   r_a;
    logic                r_ce;
    logic                r_oe;
    logic                r_we;
    logic                r_rp;
    logic                r_busy;
    logic                r_done;
    logic                r_error;
    logic                r_timeout;
    logic [DATA_W-1:0]   r_rd_cap;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_sts_s1;
    logic                r_sts_s2;

    logic                w_ph_end;
    logic                w_tmr_en;
    logic                w_tmr_zero;
    logic                w_sts_ok;
    logic [CNT_W-1:0]    w_tmr_val;
    logic [CNT_W-1:0]    w_tmr_cnt;

    function automatic logic [DATA_W-1:0] ext(input logic [7:0] c);
        return DATA_W'(c);
    endfunction

    flash_cycle_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .i_clk      (CLK_50MHZ),
        .i_rst      (RST),
        .i_load     (w_ph_end),
        .i_load_val (w_tmr_val),
        .i_en       (w_tmr_en),
        .o_count    (w_tmr_cnt),
        .o_zero_c   (w_tmr_zero)
    );

    // Current phase ends this cycle; the timer is reloaded for the next one
    always_comb begin
        w_ph_end = 1'b0;
        case (r_ph)
            PH_SETUP, PH_HOLD, PH_REC: w_ph_end = 1'b1;
            PH_WEL, PH_GAP, PH_RD:     w_ph_end = w_tmr_zero;
            default: begin
                case (r_state)
                    ST_IDLE:     w_ph_end = start;
                    ST_WAIT_STS: w_ph_end = w_sts_ok || w_tmr_zero;
                    ST_FINISH:   w_ph_end = 1'b1;
                    default:     w_ph_end = 1'b0;
                endcase
            end
        endcase
    end

    // Reload value for the phase being entered; untimed phases ignore it
    always_comb begin
        w_tmr_val = CNT_W'(T_RD - 1);
        if (r_ph == PH_SETUP) begin
            w_tmr_val = CNT_W'(T_WP - 1);
        end else if (r_ph == PH_HOLD) begin
            w_tmr_val = CNT_W'(T_WH - 1);
        end else if (r_state == ST_CMD2) begin
            w_tmr_val = CNT_W'(T_TIMEOUT - 1);
        end
    end

    assign w_tmr_en = (r_state != ST_IDLE);
    // The first two wait cycles are masked to cover the STS assertion delay
    assign w_sts_ok = (r_state == ST_WAIT_STS) && r_sts_s2 &&
                      (w_tmr_cnt < CNT_W'(T_TIMEOUT - 2));

    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            r_sts_s1 <= 1'b0;
            r_sts_s2 <= 1'b0;
        end else begin
            r_sts_s1 <= NF_STS;
            r_sts_s2 <= r_sts_s1;
        end
    end

    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_ph      <= PH_NONE;
            r_is_prog <= 1'b0;
            r_wdata   <= '0;
            r_d       <= '0;
            r_d_oe    <= 1'b0;
            r_a       <= '0;
            r_ce      <= 1'b1;
            r_oe      <= 1'b1;
            r_we      <= 1'b1;
            r_rp      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_timeout <= 1'b0;
            r_rd_cap  <= '0;
            r_rdata   <= '0;
        end else begin
            r_rp   <= 1'b1;
            r_done <= 1'b0;
            case (r_ph)
                PH_SETUP: begin
                    r_we <= 1'b0;
                    r_ph <= PH_WEL;
                end
                PH_WEL: begin
                    if (w_tmr_zero) begin
                        r_we <= 1'b1;
                        r_ph <= PH_HOLD;
                    end
                end
                PH_HOLD: begin
                    r_ce   <= 1'b1;
                    r_d_oe <= 1'b0;
                    r_ph   <= PH_GAP;
                end
                PH_GAP: begin
                    if (w_tmr_zero) begin
                        case (r_state)
                            ST_CMD1: begin
                                r_state <= ST_CMD2;
                                r_ph    <= PH_SETUP;
                                r_ce    <= 1'b0;
                                r_d_oe  <= 1'b1;
                                r_d     <= r_is_prog ? r_wdata : ext(CMD_CONFIRM);
                            end
                            ST_CMD2: begin
                                r_state <= ST_WAIT_STS;
                                r_ph    <= PH_NONE;
                            end
                            ST_STATUS: begin
                                r_ph <= PH_RD;
                                r_ce <= 1'b0;
                                r_oe <= 1'b0;
                            end
                            ST_CLR: begin
                                r_state <= ST_ARRAY;
                                r_ph    <= PH_SETUP;
                                r_ce    <= 1'b0;
                                r_d_oe  <= 1'b1;
                                r_d     <= ext(CMD_RDARR);
                            end
                            default: begin
                                r_state <= ST_FINISH;
                                r_ph    <= PH_NONE;
                            end
                        endcase
                    end
                end
                PH_RD: begin
                    if (w_tmr_zero) begin
                        r_rd_cap <= NF_D;
                        r_ce     <= 1'b1;
                        r_oe     <= 1'b1;
                        r_ph     <= PH_REC;
                        if (r_state == ST_STATUS) begin
                            r_error <= sr_has_error(8'(NF_D));
                        end
                    end
                end
                PH_REC: begin
                    if (r_state == ST_STATUS) begin
                        r_ph   <= PH_SETUP;
                        r_ce   <= 1'b0;
                        r_d_oe <= 1'b1;
                        if (r_error) begin
                            r_state <= ST_CLR;
                            r_d     <= ext(CMD_CLRSR);
                        end else begin
                            r_state <= ST_ARRAY;
                            r_d     <= ext(CMD_RDARR);
                        end
                    end else begin
                        r_state <= ST_FINISH;
                        r_ph    <= PH_NONE;
                    end
                end
                default: begin
                    case (r_state)
                        ST_IDLE: begin
                            if (start) begin
                                r_busy    <= 1'b1;
                                r_a       <= addr;
                                r_wdata   <= wdata;
                                r_error   <= 1'b0;
                                r_timeout <= 1'b0;
                                r_rd_cap  <= '0;
                                r_ce      <= 1'b0;
                                r_is_prog <= (op == OP_PROG);
                                if (op == OP_PROG || op == OP_ERASE) begin
                                    r_state <= ST_CMD1;
                                    r_ph    <= PH_SETUP;
                                    r_d_oe  <= 1'b1;
                                    r_d     <= (op == OP_PROG) ? ext(CMD_PROG) : ext(CMD_ERASE);
                                end else begin
                                    r_state <= ST_READ;
                                    r_ph    <= PH_RD;
                                    r_oe    <= 1'b0;
                                end
                            end
                        end
                        ST_WAIT_STS: begin
                            if (w_sts_ok) begin
                                r_state <= ST_STATUS;
                                r_ph    <= PH_SETUP;
                                r_ce    <= 1'b0;
                                r_d_oe  <= 1'b1;
                                r_d     <= ext(CMD_RDSR);
                            end else if (w_tmr_zero) begin
                                r_timeout <= 1'b1;
                                r_error   <= 1'b1;
                                r_state   <= ST_CLR;
                                r_ph      <= PH_SETUP;
                                r_ce      <= 1'b0;
                                r_d_oe    <= 1'b1;
                                r_d       <= ext(CMD_CLRSR);
                            end
                        end
                        ST_FINISH: begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_rdata <= r_rd_cap;
                            r_state <= ST_IDLE;
                        end
                        default: r_state <= ST_IDLE;
                    endcase
                end
            endcase
        end
    end

    assign NF_CE   = r_ce;
    assign NF_OE   = r_oe;
    assign NF_WE   = r_we;
    assign NF_RP   = r_rp;
    assign NF_WP   = 1'b1;
    assign NF_BYTE = (DATA_W == 16);
    assign NF_A    = r_a;
    assign NF_D    = r_d_oe ? r_d : {DATA_W{1'bz}};
    assign busy    = r_busy;
    assign done    = r_done;
    assign rdata   = r_rdata;
    assign error   = r_error;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_flash_ctrl.sv
// Self-checking bench for flash_ctrl with a behavioural NOR flash model.
module tb_flash_ctrl;

    localparam int T_RD  = 6;
    localparam int T_WP  = 4;
    localparam int T_WH  = 2;
    localparam int T_TMO = 100;
    localparam int WRC_PERIOD = 1 + T_WP + 1 + T_WH;

    logic       clk, rst, start;
    logic [1:0] op;
    logic [7:0] addr, wdata;
    logic       nf_ce, nf_byte, nf_oe, nf_rp, nf_we, nf_wp, nf_sts;
    logic [7:0] nf_a;
    wire  [7:0] nf_d;
    logic       busy, done, error, timeout;
    logic [7:0] rdata;

    flash_ctrl #(
        .ADDR_W(8), .DATA_W(8), .T_RD(T_RD), .T_WP(T_WP), .T_WH(T_WH), .T_TIMEOUT(T_TMO)
    ) dut (
        .CLK_50MHZ(clk), .RST(rst),
        .NF_CE(nf_ce), .NF_BYTE(nf_byte), .NF_OE(nf_oe), .NF_RP(nf_rp),
        .NF_WE(nf_we), .NF_WP(nf_wp), .NF_STS(nf_sts), .NF_A(nf_a), .NF_D(nf_d),
        .addr(addr), .wdata(wdata), .op(op), .start(start),
        .busy(busy), .done(done), .rdata(rdata), .error(error), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Flash model: drives read data, records write pulses, models STS busy time
    logic [7:0] m_rd_val;
    int         m_busy_len;
    bit         m_stuck;
    int         m_busy_cnt = 0;
    logic       prev_we = 1'b1;
    int         cyc = 0;
    int         oe_cnt = 0;
    int         done_cnt = 0;
    logic [7:0] wr_d[$];
    logic [7:0] wr_a[$];
    int         wfall_t[$];

    assign nf_d = (!nf_ce && !nf_oe) ? m_rd_val : 8'hzz;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (prev_we && !nf_we) wfall_t.push_back(cyc);
            if (!prev_we && nf_we) begin
                wr_d.push_back(nf_d);
                wr_a.push_back(nf_a);
                if (wr_d.size() == 2) m_busy_cnt = m_busy_len;
            end else if (m_busy_cnt > 0) begin
                m_busy_cnt--;
            end
            if (!nf_oe) oe_cnt++;
            if (done) done_cnt++;
        end
        prev_we = nf_we;
        nf_sts  = !(m_stuck || (m_busy_cnt > 0));
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [1:0]      op;
        logic [7:0]      addr;
        logic [7:0]      wd;
        logic [7:0]      rv;
        int              busy_len;
        bit              stuck;
        logic [7:0]      exp_rd;
        bit              chk_rd;
        bit              exp_err;
        bit              exp_tmo;
        int              nwr;
        logic [0:4][7:0] exp_wr;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] o, input logic [7:0] a, input logic [7:0] wd,
                                input logic [7:0] rv, input int bl, input bit st,
                                input logic [7:0] erd, input bit crd, input bit ee, input bit et,
                                input int nw, input logic [0:4][7:0] ew);
        vec_t v;
        v.op = o; v.addr = a; v.wd = wd; v.rv = rv; v.busy_len = bl; v.stuck = st;
        v.exp_rd = erd; v.chk_rd = crd; v.exp_err = ee; v.exp_tmo = et; v.nwr = nw; v.exp_wr = ew;
        return v;
    endfunction

    // Issue one request and wait (bounded) for done; capture results with done
    task automatic run_op(input logic [1:0] o, input logic [7:0] a, input logic [7:0] d,
                          output int lat, output bit ok, output logic [7:0] rd,
                          output logic er, output logic to);
        @(negedge clk);
        op = o; addr = a; wdata = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1; ok = 1'b0; rd = 8'h00; er = 1'b0; to = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (done) begin
                ok = 1'b1; rd = rdata; er = error; to = timeout;
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic clear_mon();
        wr_d.delete(); wr_a.delete(); wfall_t.delete(); oe_cnt = 0;
    endtask

    localparam int NV = 8;
    vec_t       vecs[NV];
    vec_t       v;
    int         lat, d0;
    bit         ok, addr_ok;
    logic [7:0] rd;
    logic       er, to;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk(2'b00, 8'h35, 8'h00, 8'hC9, 0,  1'b0, 8'hC9, 1'b1, 1'b0, 1'b0, 0, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
        vecs[1] = mk(2'b01, 8'h35, 8'hC9, 8'h80, 20, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0, 4, {8'h40, 8'hC9, 8'h70, 8'hFF, 8'h00});
        vecs[2] = mk(2'b10, 8'h35, 8'h00, 8'hA0, 20, 1'b0, 8'hA0, 1'b1, 1'b1, 1'b0, 5, {8'h20, 8'hD0, 8'h70, 8'h50, 8'hFF});
        vecs[3] = mk(2'b01, 8'h35, 8'hC9, 8'h00, 0,  1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 4, {8'h40, 8'hC9, 8'h50, 8'hFF, 8'h00});
        vecs[4] = mk(2'b11, 8'h0F, 8'h00, 8'h5A, 0,  1'b0, 8'h5A, 1'b1, 1'b0, 1'b0, 0, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
        vecs[5] = mk(2'b01, 8'h12, 8'h3C, 8'h90, 5,  1'b0, 8'h90, 1'b1, 1'b1, 1'b0, 5, {8'h40, 8'h3C, 8'h70, 8'h50, 8'hFF});
        vecs[6] = mk(2'b10, 8'hF0, 8'h00, 8'h84, 30, 1'b0, 8'h84, 1'b1, 1'b0, 1'b0, 4, {8'h20, 8'hD0, 8'h70, 8'hFF, 8'h00});
        vecs[7] = mk(2'b10, 8'h01, 8'h00, 8'h82, 0,  1'b0, 8'h82, 1'b1, 1'b1, 1'b0, 5, {8'h20, 8'hD0, 8'h70, 8'h50, 8'hFF});

        rst = 1'b1; start = 1'b0; op = 2'b00; addr = 8'h00; wdata = 8'h00;
        m_rd_val = 8'h00; m_busy_len = 0; m_stuck = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ce", 32'(nf_ce), 32'd1);
        chk("rst_oe", 32'(nf_oe), 32'd1);
        chk("rst_we", 32'(nf_we), 32'd1);
        chk("rst_rp", 32'(nf_rp), 32'd0);
        chk("rst_a", 32'(nf_a), 32'd0);
        chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
        chk("rst_err_tmo", {30'd0, error, timeout}, 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("const_byte_wp", {30'd0, nf_byte, nf_wp}, 32'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rp_after_rst", 32'(nf_rp), 32'd1);

        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            clear_mon();
            m_rd_val = v.rv; m_busy_len = v.busy_len; m_stuck = v.stuck;
            d0 = done_cnt;
            run_op(v.op, v.addr, v.wd, lat, ok, rd, er, to);
            chk($sformatf("v%0d_done", i), 32'(ok), 32'd1);
            if (v.chk_rd) chk($sformatf("v%0d_rdata", i), 32'(rd), 32'(v.exp_rd));
            chk($sformatf("v%0d_error", i), 32'(er), 32'(v.exp_err));
            chk($sformatf("v%0d_timeout", i), 32'(to), 32'(v.exp_tmo));
            chk($sformatf("v%0d_nwr", i), 32'(wr_d.size()), 32'(v.nwr));
            for (int j = 0; j < v.nwr && j < wr_d.size(); j++)
                chk($sformatf("v%0d_wr%0d", i, j), 32'(wr_d[j]), 32'(v.exp_wr[j]));
            addr_ok = 1'b1;
            foreach (wr_a[j]) if (wr_a[j] !== v.addr) addr_ok = 1'b0;
            chk($sformatf("v%0d_wr_addr", i), 32'(addr_ok), 32'd1);
            if (v.nwr == 0) begin
                chk($sformatf("v%0d_latency", i), 32'(lat), 32'(T_RD + 3));
                chk($sformatf("v%0d_oe_cycles", i), 32'(oe_cnt), 32'(T_RD));
            end
            if (wfall_t.size() >= 2)
                chk($sformatf("v%0d_wrc_period", i), 32'(wfall_t[1] - wfall_t[0]), 32'(WRC_PERIOD));
            if (v.exp_tmo && wfall_t.size() >= 3)
                chk($sformatf("v%0d_tmo_wait", i), 32'(wfall_t[2] - wfall_t[1]),
                    32'(T_WP + 1 + T_WH + T_TMO + 1));
            repeat (5) @(negedge clk);
            chk($sformatf("v%0d_one_done", i), 32'(done_cnt - d0), 32'd1);
            m_stuck = 1'b0;
        end

        // Start while busy: second request during WAIT_STS must be ignored
        clear_mon();
        m_rd_val = 8'h80; m_busy_len = 40; m_stuck = 1'b0;
        d0 = done_cnt;
        @(negedge clk);
        op = 2'b01; addr = 8'h35; wdata = 8'hC9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200 && wr_d.size() < 2; i++) @(negedge clk);
        repeat (6) @(negedge clk);
        op = 2'b00; addr = 8'hAA; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start_addr", 32'(nf_a), 32'h35);
        chk("busy_start_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 500 && !done; i++) @(negedge clk);
        chk("busy_start_rdata", 32'(rdata), 32'h80);
        repeat (20) @(negedge clk);
        chk("busy_start_one_done", 32'(done_cnt - d0), 32'd1);
        chk("busy_start_nwr", 32'(wr_d.size()), 32'd4);
        chk("busy_start_oe", 32'(oe_cnt), 32'(T_RD));

        // Reset during the CMD2 WE-low phase
        clear_mon();
        m_busy_len = 20;
        d0 = done_cnt;
        @(negedge clk);
        op = 2'b01; addr = 8'h35; wdata = 8'hC9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200 && wfall_t.size() < 2; i++) @(negedge clk);
        chk("mid_rst_we_low", 32'(nf_we), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_we", 32'(nf_we), 32'd1);
        chk("mid_rst_ce", 32'(nf_ce), 32'd1);
        chk("mid_rst_rp", 32'(nf_rp), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_d_released", 32'(dut.r_d_oe), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
        chk("mid_rst_rp_back", 32'(nf_rp), 32'd1);
        clear_mon();
        m_rd_val = 8'h6E;
        run_op(2'b00, 8'h44, 8'h00, lat, ok, rd, er, to);
        chk("post_rst_read_done", 32'(ok), 32'd1);
        chk("post_rst_read_rdata", 32'(rd), 32'h6E);
        chk("post_rst_read_lat", 32'(lat), 32'(T_RD + 3));
        chk("post_rst_read_addr", 32'(nf_a), 32'h44);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
